// File: rtl/binary_div_14_7_uni.sv
// binary_div_14_7_uni: restoring radix-2 divider, 14-bit dividend by 7-bit divisor, one quotient bit per enabled cycle.
// Latency: done is high 14 enabled cycles after the accepting edge. With DIV_BY_ZERO_FLAG_EN, B=0 goes to DONE directly.
// Backpressure: none. en=0 freezes all state. start is ignored while busy. Q/R/dbz hold until the next result.
// Optional feature macro: DIV_BY_ZERO_FLAG_EN (adds the dbz port and the B=0 fast path).
module binary_div_14_7_uni (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  input  logic [13:0] A,
  input  logic [6:0]  B,
  output logic        busy,
  output logic        done,
  output logic [13:0] Q,
  output logic [6:0]  R
`ifdef DIV_BY_ZERO_FLAG_EN
  ,
  output logic        dbz
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [3:0]  r_cnt;
  logic [13:0] r_dvd;   // dividend shifting out MSB first; quotient bits shift in at the LSB
  logic [6:0]  r_dvs;
  logic [6:0]  r_rem;   // partial remainder; always < divisor when divisor != 0
  logic [13:0] r_q;
  logic [6:0]  r_r;
`ifdef DIV_BY_ZERO_FLAG_EN
  logic        r_dbz;
`endif

  logic        w_accept;
  logic        w_zero_skip;
  logic [7:0]  w_shift;
  logic        w_ge;
  logic [6:0]  w_sub;
  logic [6:0]  w_rem_nxt;
  logic [13:0] w_dvd_nxt;
  logic        w_last;

  // A new request is taken in any state except RUN.
  assign w_accept = start && (r_state != S_RUN);

`ifdef DIV_BY_ZERO_FLAG_EN
  assign w_zero_skip = (B == 7'd0);
`else
  assign w_zero_skip = 1'b0;
`endif

  // One restoring step. The shifted remainder needs 8 bits before the compare.
  // When the compare succeeds the difference is below the divisor, so 7 bits hold it exactly.
  assign w_shift   = {r_rem, r_dvd[13]};
  assign w_ge      = (w_shift >= {1'b0, r_dvs});
  assign w_sub     = w_shift[6:0] - r_dvs;
  assign w_rem_nxt = w_ge ? w_sub : w_shift[6:0];
  assign w_dvd_nxt = {r_dvd[12:0], w_ge};
  assign w_last    = (r_cnt == 4'd1);

  // State register: reset wins over everything, en gates all movement.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (en) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic for IDLE -> RUN -> DONE, with back-to-back restart from DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = w_zero_skip ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) w_state_nxt = w_zero_skip ? S_DONE : S_RUN;
        else       w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are decoded straight from the state; results come from their holding registers.
  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
    Q    = r_q;
    R    = r_r;
`ifdef DIV_BY_ZERO_FLAG_EN
    dbz  = r_dbz;
`endif
  end

  // Datapath: capture operands on accept, iterate in RUN, publish the result only on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 4'd0;
      r_dvd <= 14'd0;
      r_dvs <= 7'd0;
      r_rem <= 7'd0;
      r_q   <= 14'd0;
      r_r   <= 7'd0;
`ifdef DIV_BY_ZERO_FLAG_EN
      r_dbz <= 1'b0;
`endif
    end else if (en) begin
      if (w_accept) begin
        r_dvd <= A;
        r_dvs <= B;
        r_rem <= 7'd0;
        r_cnt <= w_zero_skip ? 4'd0 : 4'd14;
`ifdef DIV_BY_ZERO_FLAG_EN
        if (w_zero_skip) begin
          r_q   <= 14'h3FFF;
          r_r   <= 7'd0;
          r_dbz <= 1'b1;
        end
`endif
      end else if (r_state == S_RUN) begin
        r_dvd <= w_dvd_nxt;
        r_rem <= w_rem_nxt;
        r_cnt <= r_cnt - 4'd1;
        if (w_last) begin
          // A zero divisor leaves the remainder meaningless, so pin the result explicitly.
          if (r_dvs == 7'd0) begin
            r_q <= 14'h3FFF;
            r_r <= 7'd0;
          end else begin
            r_q <= w_dvd_nxt;
            r_r <= w_rem_nxt;
          end
`ifdef DIV_BY_ZERO_FLAG_EN
          r_dbz <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_binary_div_14_7_uni.sv
// Testbench for binary_div_14_7_uni: directed scenarios plus randomized runs against an arithmetic model.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at the same point.
// Enable patterns: always on, alternating, and random.
module tb_binary_div_14_7_uni;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        start;
  logic [13:0] A;
  logic [6:0]  B;
  logic        busy;
  logic        done;
  logic [13:0] Q;
  logic [6:0]  R;
`ifdef DIV_BY_ZERO_FLAG_EN
  logic        dbz;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  binary_div_14_7_uni dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .R     (R)
`ifdef DIV_BY_ZERO_FLAG_EN
    ,
    .dbz   (dbz)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer division, with the fixed B=0 result.
  function automatic logic [31:0] ref_q(input int a, input int b);
    return (b == 0) ? 32'd16383 : 32'(a / b);
  endfunction

  function automatic logic [31:0] ref_r(input int a, input int b);
    return (b == 0) ? 32'd0 : 32'(a % b);
  endfunction

  // Number of enabled edges after the accepting edge until done is visible.
  function automatic int ref_lat(input int b);
`ifdef DIV_BY_ZERO_FLAG_EN
    return (b == 0) ? 0 : 14;
`else
    if (b < 0) return 0;
    return 14;
`endif
  endfunction

  // Present a request for one enabled edge, then scramble the operand inputs.
  task automatic start_op(input int a, input int b);
    A     = 14'(a);
    B     = 7'(b);
    start = 1'b1;
    en    = 1'b1;
    step();
    start = 1'b0;
    A     = 14'($urandom_range(0, 16383));
    B     = 7'($urandom_range(0, 127));
  endtask

  // mode 0: en always high; mode 1: en alternates, with stray starts; mode 2: en random.
  task automatic wait_done(input int mode, input int a, input int b, input string tag);
    int   edges;
    int   busy_n;
    int   cyc;
    logic seen;
    logic cur_en;
    edges  = 0;
    busy_n = 0;
    cyc    = 0;
    seen   = 1'b0;
    cur_en = 1'b1;
    while (cyc < 200) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_n++;
      case (mode)
        0:       cur_en = 1'b1;
        1:       cur_en = ~cur_en;
        default: cur_en = ($urandom_range(0, 3) != 0);
      endcase
      en = cur_en;
      if (mode == 1) begin
        start = 1'($urandom_range(0, 1));
        A     = 14'd0;
        B     = 7'd1;
      end
      step();
      if (cur_en) edges++;
      cyc++;
    end
    start = 1'b0;
    en    = 1'b1;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(edges), 32'(ref_lat(b)));
    if (mode == 0) chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(ref_lat(b)));
    chk({tag, "_Q"}, 32'(Q), ref_q(a, b));
    chk({tag, "_R"}, 32'(R), ref_r(a, b));
`ifdef DIV_BY_ZERO_FLAG_EN
    chk({tag, "_dbz"}, 32'(dbz), 32'(b == 0));
`endif
  endtask

  initial begin
    logic seen;
    int   a;
    int   b;
    int   pa;
    int   pb;
    rst   = 1'b1;
    en    = 1'b0;
    start = 1'b0;
    A     = 14'd0;
    B     = 7'd0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_Q", 32'(Q), 32'd0);
    chk("rst_R", 32'(R), 32'd0);
`ifdef DIV_BY_ZERO_FLAG_EN
    chk("rst_dbz", 32'(dbz), 32'd0);
`endif
    rst = 1'b0;

    // Maximum operands, accepted on the first edge after reset.
    start_op(16383, 127);
    chk("max_busy_after_accept", 32'(busy), 32'd1);
    wait_done(0, 16383, 127, "max");
    step();
    chk("max_done_one_cycle", 32'(done), 32'd0);
    chk("max_idle_busy", 32'(busy), 32'd0);
    chk("max_Q_hold_idle", 32'(Q), 32'd129);

    // Back-to-back request issued in the DONE cycle.
    start_op(100, 7);
    wait_done(0, 100, 7, "b2b_first");
    start_op(5, 9);
    chk("b2b_no_idle", 32'(busy), 32'd1);
    chk("b2b_Q_hold_run", 32'(Q), 32'd14);
    chk("b2b_R_hold_run", 32'(R), 32'd2);
    wait_done(0, 5, 9, "b2b_second");

    // Freeze while in DONE: done stays high until an enabled edge.
    en = 1'b0;
    step();
    step();
    step();
    chk("freeze_done_held", 32'(done), 32'd1);
    chk("freeze_R_held", 32'(R), 32'd5);
    en = 1'b1;
    step();
    chk("freeze_release", 32'(done), 32'd0);

    // Alternating enable with ignored starts during RUN.
    start_op(1000, 3);
    wait_done(1, 1000, 3, "en_toggle");
    step();

    // Divide by zero.
    start_op(500, 0);
    wait_done(0, 500, 0, "div0");
    step();

    // Reset after six iterations aborts the operation.
    start_op(9999, 50);
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_Q", 32'(Q), 32'd0);
    chk("abort_R", 32'(R), 32'd0);
    seen = 1'b0;
    repeat (20) begin
      if (done) seen = 1'b1;
      step();
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    start_op(9999, 50);
    wait_done(0, 9999, 50, "after_abort");
    step();

    // Randomized runs with boundary operands mixed in; results must hold through idle gaps.
    pa = 9999;
    pb = 50;
    for (int i = 0; i < 300; i++) begin
      case (i)
        0:       begin a = 0;     b = 1;   end
        1:       begin a = 16383; b = 1;   end
        2:       begin a = 126;   b = 127; end
        3:       begin a = 127;   b = 127; end
        4:       begin a = 0;     b = 0;   end
        default: begin
          a = int'($urandom_range(0, 16383));
          b = (i % 23 == 0) ? 0 : int'($urandom_range(1, 127));
        end
      endcase
      if (!done && $urandom_range(0, 1) == 1) begin
        step();
        chk("rnd_Q_hold_idle", 32'(Q), ref_q(pa, pb));
      end
      start_op(a, b);
      wait_done(i % 3, a, b, "rnd");
      pa = a;
      pb = b;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
